// File: rtl/ni_outstanding_tracker.sv
// Per-ID outstanding-transaction tracker for the NI initiator: separate read/write
// tables, same-ID same-target ordering, bounded per-ID depth and sticky underflow flag.
module ni_outstanding_tracker #(
  parameter int unsigned NUM_IDS     = 16,
  parameter int unsigned LOG_NUM_IDS = 4,
  parameter int unsigned CNT_WD      = 4,
  parameter int unsigned TARGET_WD   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic                   issue_is_read_i,
  input  logic [LOG_NUM_IDS-1:0] issue_id_i,
  input  logic [TARGET_WD-1:0]   issue_target_i,
  output logic                   issue_grant_o,
  input  logic                   retire_valid_i,
  input  logic                   retire_is_read_i,
  input  logic [LOG_NUM_IDS-1:0] retire_id_i,
  output logic [NUM_IDS-1:0]     response_awaited_o,
  output logic                   wait_read_response_o,
  output logic                   idle_o,
  output logic                   err_underflow_o
);

  localparam logic [CNT_WD-1:0] MaxOuts = '1;

  logic [CNT_WD-1:0]    rd_cnt_q [NUM_IDS];
  logic [CNT_WD-1:0]    rd_cnt_d [NUM_IDS];
  logic [CNT_WD-1:0]    wr_cnt_q [NUM_IDS];
  logic [CNT_WD-1:0]    wr_cnt_d [NUM_IDS];
  logic [TARGET_WD-1:0] rd_tgt_q [NUM_IDS];
  logic [TARGET_WD-1:0] rd_tgt_d [NUM_IDS];
  logic [TARGET_WD-1:0] wr_tgt_q [NUM_IDS];
  logic [TARGET_WD-1:0] wr_tgt_d [NUM_IDS];
  logic                 err_q;
  logic                 err_d;

  logic [CNT_WD-1:0]    iss_cnt;
  logic [TARGET_WD-1:0] iss_tgt;
  logic [CNT_WD-1:0]    ret_cnt;
  logic [NUM_IDS-1:0]   rd_inc;
  logic [NUM_IDS-1:0]   rd_dec;
  logic [NUM_IDS-1:0]   wr_inc;
  logic [NUM_IDS-1:0]   wr_dec;
  logic [NUM_IDS-1:0]   rd_busy;

  // Grant uses pre-edge state only, so a same-cycle retire cannot unblock an issue.
  always_comb begin
    iss_cnt = issue_is_read_i ? rd_cnt_q[issue_id_i] : wr_cnt_q[issue_id_i];
    iss_tgt = issue_is_read_i ? rd_tgt_q[issue_id_i] : wr_tgt_q[issue_id_i];
    ret_cnt = retire_is_read_i ? rd_cnt_q[retire_id_i] : wr_cnt_q[retire_id_i];
    issue_grant_o = issue_valid_i && (iss_cnt != MaxOuts) &&
                    ((iss_cnt == '0) || (iss_tgt == issue_target_i));
  end

  always_comb begin
    rd_inc = '0;
    rd_dec = '0;
    wr_inc = '0;
    wr_dec = '0;
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      rd_inc[i] = issue_grant_o && issue_is_read_i && (issue_id_i == LOG_NUM_IDS'(i));
      wr_inc[i] = issue_grant_o && !issue_is_read_i && (issue_id_i == LOG_NUM_IDS'(i));
      rd_dec[i] = retire_valid_i && retire_is_read_i &&
                  (retire_id_i == LOG_NUM_IDS'(i)) && (rd_cnt_q[i] != '0);
      wr_dec[i] = retire_valid_i && !retire_is_read_i &&
                  (retire_id_i == LOG_NUM_IDS'(i)) && (wr_cnt_q[i] != '0);
    end
  end

  // Issue and retire on the same counter cancel; target always follows the issue.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    rd_tgt_d = rd_tgt_q;
    wr_tgt_d = wr_tgt_q;
    err_d    = err_q || (retire_valid_i && (ret_cnt == '0));
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      rd_cnt_d[i] = rd_cnt_q[i] + CNT_WD'(rd_inc[i]) - CNT_WD'(rd_dec[i]);
      wr_cnt_d[i] = wr_cnt_q[i] + CNT_WD'(wr_inc[i]) - CNT_WD'(wr_dec[i]);
      if (rd_inc[i]) rd_tgt_d[i] = issue_target_i;
      if (wr_inc[i]) wr_tgt_d[i] = issue_target_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_IDS); i++) begin
        rd_cnt_q[i] <= '0;
        wr_cnt_q[i] <= '0;
        rd_tgt_q[i] <= '0;
        wr_tgt_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      rd_tgt_q <= rd_tgt_d;
      wr_tgt_q <= wr_tgt_d;
      err_q    <= err_d;
    end
  end

  // Status outputs decode registered counters only.
  always_comb begin
    response_awaited_o = '0;
    rd_busy            = '0;
    for (int i = 0; i < int'(NUM_IDS); i++) begin
      rd_busy[i]            = (rd_cnt_q[i] != '0);
      response_awaited_o[i] = rd_busy[i] || (wr_cnt_q[i] != '0);
    end
    wait_read_response_o = |rd_busy;
    idle_o               = ~|response_awaited_o;
    err_underflow_o      = err_q;
  end

endmodule

// File: doc/ni_outstanding_tracker.md
Name: ni_outstanding_tracker

Overview:
- Parametrised outstanding-transaction tracker for the AXI NI initiator.
- Generalises the fixed 16-entry response_awaited / decr_outs counter scheme to NUM_IDS IDs with independent read and write tables.
- Enforces AXI same-ID ordering: a new transaction on an ID with outstanding traffic may only issue if it goes to the same target. Per-ID outstanding depth is bounded.
- Sits between the request path (issue side) and the response path (retire side) of the NI initiator.

Parameters:
- NUM_IDS, 16: number of AXI IDs tracked per direction.
- LOG_NUM_IDS, 4: width of ID fields; NUM_IDS = 2^LOG_NUM_IDS.
- CNT_WD, 4: per-ID counter width; maximum outstanding per ID per direction is MAX_OUTS = 2^CNT_WD - 1.
- TARGET_WD, 4: width of target index, same encoding as transaction_target.

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  request path wants to issue a transaction.
- issue_is_read  in  1  1 = read (AR) table, 0 = write (AW) table.
- issue_id  in  LOG_NUM_IDS  AXI ID of the issuing transaction.
- issue_target  in  TARGET_WD  decoded target of the issuing transaction.
- issue_grant  out  1  issue accepted this cycle.
- retire_valid  in  1  a response has fully completed: last R beat, or B.
- retire_is_read  in  1  table selector for the retire.
- retire_id  in  LOG_NUM_IDS  ID of the completed transaction.
- response_awaited  out  NUM_IDS  bit i = ID i has read or write outstanding.
- wait_read_response  out  1  any read outstanding on any ID.
- idle  out  1  all counters zero.
- err_underflow  out  1  sticky: a retire hit a zero counter.

Behaviour:
- State per table (rd, wr), per ID:
  - cnt[CNT_WD-1:0]: outstanding count.
  - tgt[TARGET_WD-1:0]: target of the outstanding transactions.
- Reset (rst low, asynchronous):
  - All cnt = 0, all tgt = 0, err_underflow = 0.
  - Hence response_awaited = 0, wait_read_response = 0, idle = 1, issue_grant = 0.
  - Reset mid-operation discards all outstanding state; no retire is needed afterwards.
- issue_grant is combinational from registered state and current inputs. Let T be the table selected by issue_is_read:
  - issue_grant = issue_valid AND T.cnt[issue_id] != MAX_OUTS AND (T.cnt[issue_id] == 0 OR T.tgt[issue_id] == issue_target).
- Grant decisions always use pre-edge state. A same-cycle retire never unblocks a same-cycle issue; the issue is granted one cycle later.
- On clk rising edge with issue_grant: T.cnt[issue_id] += 1 and T.tgt[issue_id] <= issue_target.
- On retire_valid with R.cnt[retire_id] != 0 (R = table selected by retire_is_read): R.cnt[retire_id] -= 1. tgt is not cleared; it is ignored while cnt == 0.
- Retire with counter already 0: no state change, err_underflow <= 1. err_underflow holds until reset.
- Simultaneous granted issue and retire on the same table and same ID: cnt unchanged, tgt <= issue_target (equal by the grant rule unless cnt was 0).
- Simultaneous granted issue and retire on different IDs or different tables: both take effect independently.
- Counter saturation: grant is blocked at MAX_OUTS, so no wrap-around on increment. Decrement never goes below 0.
- Outputs, all combinational from registered cnt only (no input path; value updates the cycle after the edge):
  - response_awaited[i] = (rd.cnt[i] != 0) OR (wr.cnt[i] != 0).
  - wait_read_response = OR over i of (rd.cnt[i] != 0).
  - idle = NOT (OR of response_awaited).
- Latency: issue-to-response_awaited and retire-to-response_awaited are 1 cycle.
- No internal FIFO. The caller holds issue_valid and issue fields stable until granted.

Test Plan:
- Reset, then idle cycles -> response_awaited = 16'h0000, idle = 1, issue_grant = 0, err_underflow = 0.
- Write issue id 3 target 2 -> grant same cycle; next cycle response_awaited = 16'h0008, wait_read_response = 0. Write issue id 3 target 5 -> grant 0. Retire write id 3 -> response_awaited = 0. Retry id 3 target 5 -> granted.
- 15 read issues id 7 target 1 -> all granted, rd.cnt[7] = 15, wait_read_response = 1. 16th issue -> grant 0. One retire plus a new issue in the same cycle -> issue is still blocked (pre-edge state, cnt = 15), cnt becomes 14. Retry next cycle -> granted, cnt back to 15.
- Read cnt[4] = 1 target 2. Same cycle: retire read id 4 and issue read id 4 target 6 -> grant 0. Next cycle -> grant 1, tgt = 6, cnt = 1.
- Retire write id 9 with cnt = 0 -> err_underflow rises next cycle and stays 1; counters unchanged.
- With rd.cnt[0] = 2 and wr.cnt[1] = 3, assert rst low mid-cycle asynchronously -> all outputs at reset values immediately, idle = 1. After release, issue id 0 target 9 -> granted.
